// File: rtl/muldiv_unit_if.sv
// Operand/result bundle between the execute stage and the iterative multiply/divide unit.
// The execute stage drives the request side; the unit returns busy/done and the HI/LO pair.
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             flush;
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] srca;
  logic [WIDTH-1:0] srcb;
  logic             mthi;
  logic             mtlo;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output flush, start, op, srca, srcb, mthi, mtlo,
    input  busy, done, hi, lo
  );

  modport slave (
    input  flush, start, op, srca, srcb, mthi, mtlo,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit: one radix-2 step per cycle, WIDTH+1 edges per operation.
// Operands are reduced to magnitudes on accept; signs are restored when HI/LO are written.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        reset,
  muldiv_unit_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_FINISH = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_mag_q, a_mag_d;
  logic [WIDTH-1:0]   b_mag_q, b_mag_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic               sign_a_q, sign_a_d;
  logic               sign_b_q, sign_b_d;
  logic               dz_q, dz_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  // Operand conditioning at accept time; op[0]=0 selects the signed variants.
  logic             signed_op;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_abs, b_abs;

  assign signed_op = ~bus.op[0];
  assign a_neg     = signed_op & bus.srca[WIDTH-1];
  assign b_neg     = signed_op & bus.srcb[WIDTH-1];
  assign a_abs     = a_neg ? -bus.srca : bus.srca;
  assign b_abs     = b_neg ? -bus.srcb : bus.srcb;

  // Multiply step: {partial, multiplier} shifts right, adding the multiplicand on a set LSB.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;

  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_mag_q} : '0);
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // Restoring divide step: {remainder, dividend} shifts left, quotient bits enter at the LSB.
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic               div_ge;
  logic [WIDTH-1:0]   div_rem;
  logic [2*WIDTH-1:0] div_next;
  logic               unused_div_msb;

  assign div_shift      = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_diff       = div_shift - {1'b0, b_mag_q};
  assign div_ge         = div_shift >= {1'b0, b_mag_q};
  assign div_rem        = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
  assign div_next       = {div_rem, acc_q[WIDTH-2:0], div_ge};
  assign unused_div_msb = div_diff[WIDTH];

  // Sign-corrected results, only consumed in FINISH.
  logic [2*WIDTH-1:0] prod_res;
  logic [WIDTH-1:0]   quot_res, rem_res, srca_raw;

  assign prod_res = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
  assign quot_res = (sign_a_q ^ sign_b_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_res  = sign_a_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  assign srca_raw = sign_a_q ? -a_mag_q : a_mag_q;

  always_comb begin
    // NOTE: every variable gets a hold/default value first so no path can infer a latch.
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    a_mag_d  = a_mag_q;
    b_mag_d  = b_mag_q;
    acc_d    = acc_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    dz_d     = dz_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (!bus.flush) begin
            op_d     = bus.op;
            a_mag_d  = a_abs;
            b_mag_d  = b_abs;
            sign_a_d = a_neg;
            sign_b_d = b_neg;
            dz_d     = (bus.srcb == '0);
            acc_d    = bus.op[1] ? {{WIDTH{1'b0}}, a_abs} : {{WIDTH{1'b0}}, b_abs};
            cnt_d    = '0;
            state_d  = S_RUN;
          end
        end else begin
          if (bus.mthi) hi_d = bus.srca;
          if (bus.mtlo) lo_d = bus.srca;
        end
      end

      S_RUN: begin
        if (bus.flush) begin
          state_d = S_IDLE;
        end else begin
          acc_d = op_q[1] ? div_next : mul_next;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH - 1)) state_d = S_FINISH;
        end
      end

      S_FINISH: begin
        state_d = S_IDLE;
        if (!bus.flush) begin
          done_d = 1'b1;
          unique case ({op_q[1], dz_q})
            2'b10:   {hi_d, lo_d} = {rem_res, quot_res};
            2'b11:   {hi_d, lo_d} = {srca_raw, {WIDTH{1'b1}}};
            default: {hi_d, lo_d} = prod_res;
          endcase
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state is updated only with non-blocking assignments so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      cnt_q    <= '0;
      a_mag_q  <= '0;
      b_mag_q  <= '0;
      acc_q    <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      dz_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      a_mag_q  <= a_mag_d;
      b_mag_q  <= b_mag_d;
      acc_q    <= acc_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      dz_q     <= dz_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy = (state_q != S_IDLE);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: hand-computed HI/LO results, latency, done pulse,
// flush, mthi/mtlo, ignored mid-run start and asynchronous reset.
module tb_muldiv_unit;

  localparam int W = 32;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  muldiv_unit_if #(.WIDTH(W)) bus ();

  muldiv_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the unit idle; returns at the negedge where busy has fallen.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp_hi,
                        input logic [W-1:0] exp_lo, input int pulse_at);
    int cycles;
    int dones;
    bus.start = 1'b1;
    bus.op    = op;
    bus.srca  = a;
    bus.srcb  = b;
    @(negedge clk);
    bus.start = 1'b0;
    bus.srca  = '0;
    bus.srcb  = '0;
    cycles    = 0;
    dones     = 0;
    while (bus.busy && cycles < 100) begin
      cycles++;
      if (bus.done) dones++;
      if (cycles == pulse_at) begin
        bus.start = 1'b1;
        bus.op    = 2'b11;
        bus.srca  = 32'd100;
        bus.srcb  = 32'd3;
      end else begin
        bus.start = 1'b0;
        bus.srca  = '0;
        bus.srcb  = '0;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    check({tag, "_latency"}, 64'(cycles), 64'd33);
    check({tag, "_done_early"}, 64'(dones), 64'd0);
    check({tag, "_done"}, 64'(bus.done), 64'd1);
    check({tag, "_hi"}, 64'(bus.hi), 64'(exp_hi));
    check({tag, "_lo"}, 64'(bus.lo), 64'(exp_lo));
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    reset     = 1'b0;
    bus.flush = 1'b0;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.srca  = '0;
    bus.srcb  = '0;
    bus.mthi  = 1'b0;
    bus.mtlo  = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_hi", 64'(bus.hi), 64'd0);
    check("rst_lo", 64'(bus.lo), 64'd0);
    reset = 1'b1;
    @(negedge clk);

    run_op("mult_neg3x5", 2'b00, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 0);
    // Back-to-back: the next start is driven on the cycle busy falls.
    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0);
    run_op("div_neg7by2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
    run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 0);
    run_op("divu_by0", 2'b11, 32'd100, 32'd0, 32'h0000_0064, 32'hFFFF_FFFF, 0);
    @(negedge clk);
    check("divu_by0_done_clear", 64'(bus.done), 64'd0);

    // Start pulsed mid-run must be ignored: result and latency belong to the first op.
    run_op("multu_7x6_ignstart", 2'b01, 32'd7, 32'd6, 32'd0, 32'd42, 5);
    @(negedge clk);

    // Both move-to registers at once.
    bus.mthi = 1'b1;
    bus.mtlo = 1'b1;
    bus.srca = 32'h0000_ABCD;
    @(negedge clk);
    bus.mthi = 1'b0;
    bus.mtlo = 1'b0;
    check("mthilo_hi", 64'(bus.hi), 64'h0000_ABCD);
    check("mthilo_lo", 64'(bus.lo), 64'h0000_ABCD);
    check("mthilo_done", 64'(bus.done), 64'd0);

    // Start beats mthi in the same cycle: HI is not written by the move.
    bus.mthi = 1'b1;
    bus.start = 1'b1;
    bus.op = 2'b01;
    bus.srca = 32'd2;
    bus.srcb = 32'd3;
    @(negedge clk);
    bus.mthi = 1'b0;
    bus.start = 1'b0;
    check("start_vs_mthi_busy", 64'(bus.busy), 64'd1);
    check("start_vs_mthi_hi", 64'(bus.hi), 64'h0000_ABCD);
    repeat (40) @(negedge clk);
    check("start_vs_mthi_res_hi", 64'(bus.hi), 64'd0);
    check("start_vs_mthi_res_lo", 64'(bus.lo), 64'd6);

    // Flush and start on the same edge in IDLE: nothing is accepted.
    bus.flush = 1'b1;
    bus.start = 1'b1;
    bus.op = 2'b01;
    bus.srca = 32'd9;
    bus.srcb = 32'd9;
    @(negedge clk);
    bus.flush = 1'b0;
    bus.start = 1'b0;
    check("flush_start_idle_busy", 64'(bus.busy), 64'd0);

    bus.mtlo = 1'b1;
    bus.srca = 32'h0000_1234;
    @(negedge clk);
    bus.mtlo = 1'b0;
    check("mtlo_lo", 64'(bus.lo), 64'h0000_1234);
    check("mtlo_hi_kept", 64'(bus.hi), 64'd0);

    // Flush at cycle 10 of a MULTU: HI/LO keep their pre-operation values.
    bus.start = 1'b1;
    bus.op = 2'b01;
    bus.srca = 32'd3;
    bus.srcb = 32'd4;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    check("flush_pre_busy", 64'(bus.busy), 64'd1);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    check("flush_busy", 64'(bus.busy), 64'd0);
    check("flush_done", 64'(bus.done), 64'd0);
    check("flush_lo", 64'(bus.lo), 64'h0000_1234);
    check("flush_hi", 64'(bus.hi), 64'd0);
    repeat (30) @(negedge clk);
    check("flush_late_done", 64'(bus.done), 64'd0);
    check("flush_late_lo", 64'(bus.lo), 64'h0000_1234);

    // Asynchronous reset at cycle 20 of a DIVU.
    bus.start = 1'b1;
    bus.op = 2'b11;
    bus.srca = 32'd1000;
    bus.srcb = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (19) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("async_rst_busy", 64'(bus.busy), 64'd0);
    check("async_rst_hi", 64'(bus.hi), 64'd0);
    check("async_rst_lo", 64'(bus.lo), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    run_op("divu_1000by7", 2'b11, 32'd1000, 32'd7, 32'd6, 32'd142, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit for the execute stage. It consumes forwarded operands from the execute operand muxes and produces the 64-bit HI/LO pair that feeds the execute-to-memory pipeline register inputs multhi/multlo.
- Executes MULT, MULTU, DIV and DIVU using one radix-2 step per cycle.
- Raises busy so the hazard unit can stall any instruction that reads HI/LO.

Parameters:
- WIDTH, 32, operand width and HI/LO width. The iteration count equals WIDTH.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- flush  input  1  synchronous abort of any in-flight operation
- start  input  1  operation request, sampled only while idle
- op  input  2  00=MULT, 01=MULTU, 10=DIV, 11=DIVU
- srca  input  WIDTH  multiplicand / dividend (rs)
- srcb  input  WIDTH  multiplier / divisor (rt)
- mthi  input  1  write srca into HI
- mtlo  input  1  write srca into LO
- busy  output  1  operation in flight
- done  output  1  one-cycle pulse when HI/LO are updated by an operation
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; busy=0, done=0, hi=0, lo=0.
  - All internal registers (counter, accumulators, sign flags) are cleared.
  - Reset mid-operation discards the operation.
- States: IDLE -> RUN -> FINISH -> IDLE.
- IDLE:
  - start=1 at edge E0 latches op, operand magnitudes (absolute values for MULT/DIV, raw for MULTU/DIVU), sign flags and a divide-by-zero flag.
  - Clears the counter and goes to RUN; busy=1 from E0.
- RUN:
  - One iteration per edge, E1..E_WIDTH; the counter counts 0..WIDTH-1.
  - Multiply: shift-add into a 2*WIDTH-bit product accumulator.
  - Divide: restoring shift-subtract producing a WIDTH-bit quotient and WIDTH-bit remainder.
  - Transitions to FINISH when counter==WIDTH-1.
- FINISH (edge E_WIDTH+1):
  - Sign correction, then write hi/lo:
    - MULT: {hi,lo} = two's-complement product, negated if the operand signs differ.
    - MULTU: {hi,lo} = unsigned product.
    - DIV: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
    - DIVU: lo = quotient, hi = remainder, both unsigned.
    - Divisor zero (any divide): hi = srca as latched, lo = all ones.
    - DIV with 0x80000000 / -1: lo=0x80000000, hi=0 (natural WIDTH-bit wrap).
  - done=1 for exactly the cycle after E_WIDTH+1.
  - busy=0 from the same edge. Latency is WIDTH+1 edges for every op, with no early-out.
- start while busy: ignored, with no queueing.
- start and flush on the same edge in IDLE: flush wins, nothing is latched.
- flush:
  - In RUN or FINISH at an edge: return to IDLE, busy=0, done=0.
  - hi/lo keep their pre-operation values, and no partial result is ever visible.
- mthi/mtlo:
  - Honoured only in IDLE and only when start=0. They take effect at the edge and done stays 0.
  - mthi and mtlo together write both registers.
  - Ignored while busy; the hazard unit stalls them.
- start together with mthi/mtlo in IDLE: start wins.
- hi/lo change only at FINISH, on mthi/mtlo, or on reset.
- done never asserts without a preceding accepted start.

Test Plan:
- Reset, then MULT srca=0xFFFFFFFD (-3), srcb=5 -> busy for 33 cycles, done pulse once, hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. Back-to-back start accepted on the cycle busy falls.
- DIV 0xFFFFFFF9 (-7) / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU 100 / 0 -> hi=0x00000064, lo=0xFFFFFFFF after 33 cycles.
- mtlo 0x1234 in IDLE, then MULTU 3x4 with flush at cycle 10 -> busy drops, no done, lo stays 0x1234. A start pulsed at cycle 5 of a running op is ignored.
- Assert reset at cycle 20 of a DIVU -> hi=lo=0, busy=0 immediately (asynchronous). After release, a new op completes correctly.
